// File: rtl/blk_lock_pkg.sv
// Shared types and defaults for the block-lock sequencer.
// One-hot FSM encoding, sweep length and counter widths.
package blk_lock_pkg;

  localparam int B_IDLE    = 0;
  localparam int B_WAIT    = 1;
  localparam int B_SLIP    = 2;
  localparam int B_SETTLE  = 3;
  localparam int B_LOCKED  = 4;
  localparam int B_RESTART = 5;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WAIT    = 6'b000010,
    ST_SLIP    = 6'b000100,
    ST_SETTLE  = 6'b001000,
    ST_LOCKED  = 6'b010000,
    ST_RESTART = 6'b100000
  } state_e;

  // One full 64b/66b header search visits 66 bit positions.
  localparam int SWEEP_LEN  = 66;
  localparam int SLIP_CNT_W = 7;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n, inc_i, clr_i -> cnt_o (W bits, sticks at all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/block_lock_ctrl.sv
// Slip/settle/restart sequencer between sync-header detector and RX gearbox.
// In: clk rst_n en slid_vld locked. Out: gb_slip sync_rst_n link_up
// slip_cnt retry_cnt sweep_fail; BLK_LOCK_STAT_EN adds lock_loss_cnt, slip_total.
module block_lock_ctrl
  import blk_lock_pkg::*;
#(
  parameter int SETTLE_CYC    = 32,
  parameter int MAX_SLIP      = SWEEP_LEN,
  parameter int LOCK_DEBOUNCE = 4,
  parameter int RESTART_CYC   = 16,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  slid_vld,
  input  logic                  locked,
  output logic                  gb_slip,
  output logic                  sync_rst_n,
  output logic                  link_up,
  output logic [SLIP_CNT_W-1:0] slip_cnt,
  output logic [CNT_W-1:0]      retry_cnt,
  output logic                  sweep_fail
`ifdef BLK_LOCK_STAT_EN
  ,
  output logic [CNT_W-1:0]      lock_loss_cnt,
  output logic [CNT_W-1:0]      slip_total
`endif
);

  localparam int TMR_MAX =
    (SETTLE_CYC > RESTART_CYC) ? SETTLE_CYC : RESTART_CYC;
  localparam int TMR_W = $clog2(TMR_MAX) + 1;
  localparam int DEB_W = $clog2(LOCK_DEBOUNCE) + 1;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [DEB_W-1:0]        deb_q, deb_d;
  logic [SLIP_CNT_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic                    gb_slip_q, gb_slip_d;
  logic                    sync_rst_n_q, sync_rst_n_d;
  logic                    link_up_q, link_up_d;
  logic                    sweep_fail_q, sweep_fail_d;
  logic                    retry_inc;

  always_comb begin
    state_d      = state_q;
    tmr_d        = '0;
    deb_d        = '0;
    slip_cnt_d   = slip_cnt_q;
    gb_slip_d    = 1'b0;
    sync_rst_n_d = 1'b1;
    link_up_d    = 1'b0;
    sweep_fail_d = 1'b0;
    retry_inc    = 1'b0;
    if (!en) begin
      state_d      = ST_IDLE;
      sync_rst_n_d = 1'b0;
    end else begin
      unique case (1'b1)
        state_q[B_IDLE]: begin
          state_d = ST_WAIT;
        end
        state_q[B_WAIT]: begin
          if (slid_vld) begin
            state_d = ST_SLIP;
          end else if (locked) begin
            deb_d = deb_q + 1'b1;
            if (deb_d == DEB_W'(LOCK_DEBOUNCE)) begin
              state_d    = ST_LOCKED;
              slip_cnt_d = '0;
            end
          end
        end
        state_q[B_SLIP]: begin
          // Last position of the sweep: give up instead of slipping.
          if (slip_cnt_q == SLIP_CNT_W'(MAX_SLIP - 1)) begin
            state_d      = ST_RESTART;
            sweep_fail_d = 1'b1;
            sync_rst_n_d = 1'b0;
            slip_cnt_d   = '0;
            retry_inc    = 1'b1;
          end else begin
            state_d    = ST_SETTLE;
            gb_slip_d  = 1'b1;
            slip_cnt_d = slip_cnt_q + 1'b1;
          end
        end
        state_q[B_SETTLE]: begin
          if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
            state_d = ST_WAIT;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        state_q[B_LOCKED]: begin
          if (!locked || slid_vld) begin
            state_d = ST_WAIT;
          end else begin
            link_up_d = 1'b1;
          end
        end
        state_q[B_RESTART]: begin
          if (tmr_q == TMR_W'(RESTART_CYC - 1)) begin
            state_d = ST_WAIT;
          end else begin
            tmr_d        = tmr_q + 1'b1;
            sync_rst_n_d = 1'b0;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          sync_rst_n_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      deb_q        <= '0;
      slip_cnt_q   <= '0;
      gb_slip_q    <= 1'b0;
      sync_rst_n_q <= 1'b0;
      link_up_q    <= 1'b0;
      sweep_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      deb_q        <= deb_d;
      slip_cnt_q   <= slip_cnt_d;
      gb_slip_q    <= gb_slip_d;
      sync_rst_n_q <= sync_rst_n_d;
      link_up_q    <= link_up_d;
      sweep_fail_q <= sweep_fail_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_retry (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (retry_inc),
    .clr_i (1'b0),
    .cnt_o (retry_cnt)
  );

`ifdef BLK_LOCK_STAT_EN
  logic loss_inc;

  assign loss_inc = en && state_q[B_LOCKED] && (!locked || slid_vld);

  sat_counter #(.W(CNT_W)) u_loss (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (loss_inc),
    .clr_i (1'b0),
    .cnt_o (lock_loss_cnt)
  );

  sat_counter #(.W(CNT_W)) u_slips (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (gb_slip_d),
    .clr_i (1'b0),
    .cnt_o (slip_total)
  );
`endif

  assign gb_slip    = gb_slip_q;
  assign sync_rst_n = sync_rst_n_q;
  assign link_up    = link_up_q;
  assign slip_cnt   = slip_cnt_q;
  assign sweep_fail = sweep_fail_q;

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Directed bench for block_lock_ctrl: lock, debounce, slip, sweep, reset.
// Stat counters are also checked when BLK_LOCK_STAT_EN is defined.
module tb_block_lock_ctrl;
  import blk_lock_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic                  slid_vld = 1'b0;
  logic                  locked = 1'b0;
  logic                  gb_slip;
  logic                  sync_rst_n;
  logic                  link_up;
  logic [SLIP_CNT_W-1:0] slip_cnt;
  logic [7:0]            retry_cnt;
  logic                  sweep_fail;
`ifdef BLK_LOCK_STAT_EN
  logic [7:0]            lock_loss_cnt;
  logic [7:0]            slip_total;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int gb_cnt = 0;
  int sf_cnt = 0;
  int lo_cnt = 0;
  int gb_base, sf_base, lo_base;

  block_lock_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .slid_vld   (slid_vld),
    .locked     (locked),
    .gb_slip    (gb_slip),
    .sync_rst_n (sync_rst_n),
    .link_up    (link_up),
    .slip_cnt   (slip_cnt),
    .retry_cnt  (retry_cnt),
    .sweep_fail (sweep_fail)
`ifdef BLK_LOCK_STAT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .slip_total    (slip_total)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gb_slip) gb_cnt++;
    if (sweep_fail) sf_cnt++;
    if (!sync_rst_n) lo_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_gb"},    32'(gb_slip), 0);
    chk({tag, "_sync"},  32'(sync_rst_n), 0);
    chk({tag, "_link"},  32'(link_up), 0);
    chk({tag, "_slip"},  32'(slip_cnt), 0);
    chk({tag, "_retry"}, 32'(retry_cnt), 0);
    chk({tag, "_sf"},    32'(sweep_fail), 0);
`ifdef BLK_LOCK_STAT_EN
    chk({tag, "_loss"},  32'(lock_loss_cnt), 0);
    chk({tag, "_stot"},  32'(slip_total), 0);
`endif
  endtask

  task automatic do_slips(input int n);
    for (int i = 0; i < n; i++) begin
      slid_vld = 1'b1;
      tick();
      slid_vld = 1'b0;
      repeat (39) tick();
    end
  endtask

  logic [7:0] seq;

  initial begin
    seq = 8'b1110_1111;
    repeat (3) tick();
    chk_rst_vals("por");

    // Straight lock with locked held high.
    rst_n = 1'b1;
    en = 1'b1;
    locked = 1'b1;
    gb_base = gb_cnt;
    tick();
    chk("en_sync", 32'(sync_rst_n), 1);
    chk("en_link", 32'(link_up), 0);
    repeat (4) tick();
    chk("deb_link_early", 32'(link_up), 0);
    tick();
    chk("deb_link", 32'(link_up), 1);
    chk("lock_no_gb", 32'(gb_cnt - gb_base), 0);

    // One-cycle lock loss and re-lock.
    locked = 1'b0;
    tick();
    chk("loss_link", 32'(link_up), 0);
    locked = 1'b1;
    repeat (4) tick();
    chk("relock_early", 32'(link_up), 0);
    tick();
    chk("relock_link", 32'(link_up), 1);
`ifdef BLK_LOCK_STAT_EN
    chk("loss_cnt1", 32'(lock_loss_cnt), 1);
`endif

    // Broken run: only the trailing 4-cycle run locks.
    locked = 1'b0;
    tick();
    chk("brk_drop", 32'(link_up), 0);
    for (int i = 7; i >= 0; i--) begin
      locked = seq[i];
      tick();
      chk("brk_hold", 32'(link_up), 0);
    end
    tick();
    chk("brk_link", 32'(link_up), 1);

    // Single slip and dropped requests during settle.
    locked = 1'b0;
    tick();
    chk("slip_unlock", 32'(link_up), 0);
    gb_base = gb_cnt;
    slid_vld = 1'b1;
    tick();
    slid_vld = 1'b0;
    chk("slip_lat1", 32'(gb_slip), 0);
    tick();
    chk("slip_lat2", 32'(gb_slip), 1);
    chk("slip_cnt1", 32'(slip_cnt), 1);
    tick();
    chk("slip_width", 32'(gb_slip), 0);
    for (int i = 0; i < 6; i++) begin
      slid_vld = 1'b1;
      tick();
      slid_vld = 1'b0;
      repeat (4) tick();
    end
    chk("settle_drop", 32'(gb_cnt - gb_base), 1);
    chk("settle_cnt", 32'(slip_cnt), 1);
`ifdef BLK_LOCK_STAT_EN
    chk("loss_cnt3", 32'(lock_loss_cnt), 3);
    chk("stot1", 32'(slip_total), 1);
`endif

    // Async reset mid-SETTLE.
    rst_n = 1'b0;
    #1;
    chk_rst_vals("rst_settle");
    tick();
    rst_n = 1'b1;

    // Full sweep without lock.
    tick();
    gb_base = gb_cnt;
    sf_base = sf_cnt;
    lo_base = lo_cnt;
    do_slips(66);
    chk("sweep_gb", 32'(gb_cnt - gb_base), 65);
    chk("sweep_sf", 32'(sf_cnt - sf_base), 1);
    chk("sweep_lo", 32'(lo_cnt - lo_base), 16);
    chk("sweep_retry", 32'(retry_cnt), 1);
    chk("sweep_slip", 32'(slip_cnt), 0);
    chk("sweep_sync", 32'(sync_rst_n), 1);

    // Second sweep, reset while restarting.
    do_slips(65);
    chk("sw2_slip", 32'(slip_cnt), 65);
    slid_vld = 1'b1;
    tick();
    slid_vld = 1'b0;
    tick();
    chk("sw2_sf", 32'(sweep_fail), 1);
    chk("sw2_retry", 32'(retry_cnt), 2);
    repeat (3) tick();
    chk("sw2_sync", 32'(sync_rst_n), 0);
`ifdef BLK_LOCK_STAT_EN
    chk("stot130", 32'(slip_total), 130);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst_vals("rst_restart");

    // Restart from IDLE after release.
    #2;
    rst_n = 1'b1;
    locked = 1'b1;
    tick();
    chk("post_sync", 32'(sync_rst_n), 1);
    repeat (4) tick();
    chk("post_early", 32'(link_up), 0);
    tick();
    chk("post_link", 32'(link_up), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/block_lock_ctrl.md
Name: block_lock_ctrl

Overview:
- Sequencer for the 64b/66b sync-header lock detector and the RX gearbox.
- Turns the detector's slip requests into gearbox bitslip pulses and enforces a settle window after each slip.
- Forces a detector restart when a full slip sweep fails to lock, and debounces the detector's locked output into link_up.
- Sits between the gearbox/GT slip input and the sync-header detector; link_up feeds the descrambler/decoder enable.

Parameters:
- SETTLE_CYC, 32: cycles the detector is ignored after each gearbox slip.
- MAX_SLIP, 66: slips in one sweep before a restart is forced.
- LOCK_DEBOUNCE, 4: consecutive locked cycles required before link_up.
- RESTART_CYC, 16: cycles sync_rst_n is held low during a restart.
- CNT_W, 8: width of the retry and statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  controller enable; low forces IDLE.
- slid_vld  in  1  slip request pulse from the sync-header detector.
- locked  in  1  lock level from the sync-header detector.
- gb_slip  out  1  one-cycle bitslip pulse to the gearbox.
- sync_rst_n  out  1  active-low synchronous restart for the detector.
- link_up  out  1  debounced block lock.
- slip_cnt  out  7  slips in the current sweep.
- retry_cnt  out  CNT_W  restarts since rst_n; saturating.
- sweep_fail  out  1  one-cycle pulse when a sweep is exhausted.

Behaviour:
- Reset values: state IDLE; gb_slip 0, sync_rst_n 0, link_up 0, slip_cnt 0, retry_cnt 0, sweep_fail 0. Every output is registered.
- States (one-hot): IDLE, WAIT_LOCK, SLIP, SETTLE, LOCKED, RESTART.
- en low in any state: next state IDLE; gb_slip, link_up and sync_rst_n go to 0 one cycle later; counters hold their values.
- IDLE: en high -> WAIT_LOCK; sync_rst_n goes to 1 on the transition.
- WAIT_LOCK:
  - debounce counter increments while locked=1 and clears when locked=0.
  - counter reaches LOCK_DEBOUNCE -> LOCKED.
  - slid_vld=1 -> SLIP; slid_vld takes priority over the debounce.
- SLIP (one cycle only):
  - if slip_cnt==MAX_SLIP-1: -> RESTART, sweep_fail pulses, no gb_slip is issued.
  - otherwise: gb_slip=1 on the next cycle, slip_cnt+1, -> SETTLE.
- SETTLE:
  - counts SETTLE_CYC cycles, then -> WAIT_LOCK.
  - slid_vld and locked are ignored throughout.
- LOCKED:
  - link_up=1 from the cycle after entry; slip_cnt clears to 0 on entry.
  - locked=0 or slid_vld=1 -> WAIT_LOCK; link_up drops the next cycle; the debounce counter restarts.
- RESTART:
  - sync_rst_n=0 for exactly RESTART_CYC cycles; slip_cnt clears; retry_cnt increments once, saturating at 2^CNT_W-1.
  - then -> WAIT_LOCK with sync_rst_n=1.
- Back-to-back slid_vld: requests arriving in SLIP or SETTLE are dropped, not queued. Total latency from slid_vld to gb_slip is 2 cycles.
- Asserting rst_n mid-operation returns all state and outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro BLK_LOCK_STAT_EN.
- Defined:
  - adds output lock_loss_cnt (CNT_W), incremented, saturating, on every LOCKED->WAIT_LOCK transition.
  - adds output slip_total (CNT_W), incremented, saturating, on every gb_slip pulse.
  - both clear only on rst_n.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Package blk_lock_pkg: one-hot state localparams (6 bits), the 66-position sweep constant, and the counter width defaults.
- One sub-module, sat_counter (parameterised width; inc, clr, saturate), instantiated for retry_cnt and, when BLK_LOCK_STAT_EN is defined, for lock_loss_cnt and slip_total.
- The settle and debounce counters are kept inline.

Test Plan:
- Reset then en=1, locked=1 held -> sync_rst_n=1 after 1 cycle; link_up=1 exactly LOCK_DEBOUNCE+2 cycles after en; gb_slip never pulses.
- en=1, one slid_vld pulse -> gb_slip high for exactly 1 cycle, 2 cycles later; slid_vld pulses during the next 32 cycles produce no gb_slip; slip_cnt=1.
- slid_vld pulsed once per 40 cycles, locked=0 -> 65 gb_slip pulses, then sweep_fail pulses; sync_rst_n low 16 cycles; retry_cnt=1; slip_cnt=0.
- Lock reached, then locked=0 for 1 cycle -> link_up drops next cycle; re-lock needs 4 consecutive locked cycles; lock_loss_cnt=1 with BLK_LOCK_STAT_EN.
- locked toggling 1,1,1,0,1,1,1,1 -> link_up asserted only after the final 4-cycle run.
- rst_n asserted mid-SETTLE and mid-RESTART -> all outputs at reset values in the same cycle; en=1 after release restarts from IDLE.
